// File: rtl/fpu_csr_file_pkg.sv
// Shared FPU CSR definitions: exception flag layout, CSR addresses and CSR instruction ops.
package fpu_csr_file_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'd0,
    CSR_OP_SET   = 2'd1,
    CSR_OP_CLEAR = 2'd2
  } csr_op_e;

  // Read-modify-write on the 8-bit fcsr view; an undefined op leaves the value untouched.
  function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                           input logic [7:0] old_val,
                                           input logic [7:0] operand);
    case (csr_op_e'(op))
      CSR_OP_WRITE: csr_apply = operand;
      CSR_OP_SET:   csr_apply = old_val | operand;
      CSR_OP_CLEAR: csr_apply = old_val & ~operand;
      default:      csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/fpu_csr_file_pending_ctr.sv
// Per-warp in-flight FPU op counter with one increment port and one decrement port per FPU block.
module fpu_pending_ctr #(
  parameter int PENDING_MAX = 16,
  parameter int NUM_DEC     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic [NUM_DEC-1:0] dec,
  output logic               full,
  output logic               zero
);

  localparam int CW = $clog2(PENDING_MAX + 1);
  localparam int SW = CW + $clog2(NUM_DEC + 1);

  logic [CW-1:0] count;
  logic [SW-1:0] dec_cnt;
  logic [SW-1:0] sum;

  always_comb begin
    dec_cnt = '0;
    for (int i = 0; i < NUM_DEC; i++) dec_cnt = dec_cnt + SW'(dec[i]);
  end

  assign sum = SW'(count) + SW'(inc);

  // A retire with nothing in flight is a protocol error; clamp at zero rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (dec_cnt > sum) count <= '0;
    else                    count <= CW'(sum - dec_cnt);
  end

  assign full = (count == CW'(PENDING_MAX));
  assign zero = (count == '0);

  underflow_chk: assert property (@(posedge clk) disable iff (reset) dec_cnt <= sum)
    else $error("fpu_pending_ctr: FPU commit with no op in flight");

endmodule

// File: rtl/fpu_csr_file.sv
// Per-warp FPU CSR storage (fflags, frm): frm lookup for FPU blocks, sticky fflags accrual at
// retire, and the fflags/frm/fcsr responder for CSR instructions, gated by in-flight FPU ops.
module fpu_csr_file
  import fpu_csr_file_pkg::*;
#(
  parameter int  NUM_WARPS   = 8,
  parameter int  NUM_BLOCKS  = 1,
  parameter int  PENDING_MAX = 16,
  parameter int  XLEN        = 32,
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int BLK_BITS    = $clog2(NUM_BLOCKS),
  localparam int BWW         = (NW_WIDTH - BLK_BITS > 1) ? (NW_WIDTH - BLK_BITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_BLOCKS*BWW-1:0] read_wid,
  output logic [NUM_BLOCKS*3-1:0]   read_frm,
  input  logic [NUM_BLOCKS-1:0]     write_enable,
  input  logic [NUM_BLOCKS*BWW-1:0] write_wid,
  input  logic [NUM_BLOCKS*5-1:0]   write_fflags,
  input  logic                      issue_valid,
  input  logic [NW_WIDTH-1:0]       issue_wid,
  output logic                      issue_ready,
  input  logic [NUM_BLOCKS-1:0]     commit_valid,
  input  logic [NUM_BLOCKS*BWW-1:0] commit_wid,
  input  logic                      csr_req_valid,
  output logic                      csr_req_ready,
  input  logic [NW_WIDTH-1:0]       csr_req_wid,
  input  logic [11:0]               csr_req_addr,
  input  logic [1:0]                csr_req_op,
  input  logic [XLEN-1:0]           csr_req_data,
  output logic                      csr_rsp_valid,
  input  logic                      csr_rsp_ready,
  output logic [XLEN-1:0]           csr_rsp_data
);

  fflags_t             fflags_q    [NUM_WARPS];
  logic [2:0]          frm_q       [NUM_WARPS];
  logic [4:0]          retire_or   [NUM_WARPS];
  logic [NW_WIDTH-1:0] rd_wid_full [NUM_BLOCKS];
  logic [NW_WIDTH-1:0] wr_wid_full [NUM_BLOCKS];
  logic [NW_WIDTH-1:0] cm_wid_full [NUM_BLOCKS];
  logic [NUM_WARPS-1:0] pend_full;
  logic [NUM_WARPS-1:0] pend_zero;

  logic       issue_fire;
  logic       addr_fflags, addr_frm, addr_fcsr, addr_known;
  logic       csr_accept;
  logic [7:0] old_val, new_val;
  logic       csr_fflags_wr, csr_frm_wr;
  logic [2:0] csr_frm_new;
  logic       unused_data_hi;

  // Each block owns the warps whose low wid bits equal its block index.
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    if (NUM_BLOCKS == 1) begin : g_one
      assign rd_wid_full[b] = NW_WIDTH'(read_wid[b*BWW +: BWW]);
      assign wr_wid_full[b] = NW_WIDTH'(write_wid[b*BWW +: BWW]);
      assign cm_wid_full[b] = NW_WIDTH'(commit_wid[b*BWW +: BWW]);
    end else begin : g_many
      assign rd_wid_full[b] = NW_WIDTH'({read_wid[b*BWW +: BWW], BLK_BITS'(b)});
      assign wr_wid_full[b] = NW_WIDTH'({write_wid[b*BWW +: BWW], BLK_BITS'(b)});
      assign cm_wid_full[b] = NW_WIDTH'({commit_wid[b*BWW +: BWW], BLK_BITS'(b)});
    end
    assign read_frm[b*3 +: 3] = frm_q[rd_wid_full[b]];
  end

  assign issue_ready = ~pend_full[issue_wid];
  assign issue_fire  = issue_valid && issue_ready;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [NUM_BLOCKS-1:0] dec;
    always_comb begin
      dec = '0;
      for (int b = 0; b < NUM_BLOCKS; b++)
        dec[b] = commit_valid[b] && (cm_wid_full[b] == NW_WIDTH'(w));
    end
    fpu_pending_ctr #(.PENDING_MAX(PENDING_MAX), .NUM_DEC(NUM_BLOCKS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (issue_fire && (issue_wid == NW_WIDTH'(w))),
      .dec   (dec),
      .full  (pend_full[w]),
      .zero  (pend_zero[w])
    );
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      retire_or[w] = '0;
      for (int b = 0; b < NUM_BLOCKS; b++)
        if (write_enable[b] && (wr_wid_full[b] == NW_WIDTH'(w)))
          retire_or[w] = retire_or[w] | write_fflags[b*5 +: 5];
    end
  end

  assign addr_fflags = (csr_req_addr == CSR_FFLAGS);
  assign addr_frm    = (csr_req_addr == CSR_FRM);
  assign addr_fcsr   = (csr_req_addr == CSR_FCSR);
  assign addr_known  = addr_fflags || addr_frm || addr_fcsr;

  // fflags-touching accesses wait for the warp to drain so no retire can race the RMW.
  assign csr_req_ready = ~(csr_rsp_valid && ~csr_rsp_ready)
                       && ~((addr_fflags || addr_fcsr) && ~pend_zero[csr_req_wid]);
  assign csr_accept    = csr_req_valid && csr_req_ready;

  always_comb begin
    old_val = '0;
    if (addr_fflags)    old_val = {3'b000, fflags_q[csr_req_wid]};
    else if (addr_frm)  old_val = {5'b00000, frm_q[csr_req_wid]};
    else if (addr_fcsr) old_val = {frm_q[csr_req_wid], fflags_q[csr_req_wid]};
  end

  assign new_val        = csr_apply(csr_req_op, old_val, csr_req_data[7:0]);
  assign csr_fflags_wr  = csr_accept && (addr_fflags || addr_fcsr);
  assign csr_frm_wr     = csr_accept && (addr_frm || addr_fcsr);
  assign csr_frm_new    = addr_fcsr ? new_val[7:5] : new_val[2:0];
  assign unused_data_hi = ^csr_req_data[XLEN-1:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= '0;
        frm_q[w]    <= '0;
      end
      csr_rsp_valid <= 1'b0;
      csr_rsp_data  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= fflags_t'(((csr_fflags_wr && (csr_req_wid == NW_WIDTH'(w)))
                                  ? new_val[4:0] : fflags_q[w]) | retire_or[w]);
        if (csr_frm_wr && (csr_req_wid == NW_WIDTH'(w))) frm_q[w] <= csr_frm_new;
      end
      if (csr_accept) begin
        csr_rsp_valid <= 1'b1;
        csr_rsp_data  <= XLEN'(old_val);
      end else if (csr_rsp_ready) begin
        csr_rsp_valid <= 1'b0;
      end
    end
  end

  unknown_addr_chk: assert property (@(posedge clk) disable iff (reset) csr_accept |-> addr_known)
    else $warning("fpu_csr_file: CSR access to unknown address");

endmodule

// File: tb/tb_fpu_csr_file.sv
// Randomized bench for fpu_csr_file: a per-warp reference model predicts handshakes and CSR
// responses; responses are queued at accept and checked by an independent monitor.
module tb_fpu_csr_file;
  localparam int NW   = 8;
  localparam int PMAX = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  read_wid;
  logic [2:0]  read_frm;
  logic        write_enable;
  logic [2:0]  write_wid;
  logic [4:0]  write_fflags;
  logic        issue_valid;
  logic [2:0]  issue_wid;
  logic        issue_ready;
  logic        commit_valid;
  logic [2:0]  commit_wid;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic [2:0]  csr_req_wid;
  logic [11:0] csr_req_addr;
  logic [1:0]  csr_req_op;
  logic [31:0] csr_req_data;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready;
  logic [31:0] csr_rsp_data;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_ffl [NW];
  int          m_frm [NW];
  int          m_pend [NW];
  bit          m_rsp_valid;
  int unsigned exp_q [$];

  fpu_csr_file #(.NUM_WARPS(NW), .NUM_BLOCKS(1), .PENDING_MAX(PMAX), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .read_wid      (read_wid),
    .read_frm      (read_frm),
    .write_enable  (write_enable),
    .write_wid     (write_wid),
    .write_fflags  (write_fflags),
    .issue_valid   (issue_valid),
    .issue_wid     (issue_wid),
    .issue_ready   (issue_ready),
    .commit_valid  (commit_valid),
    .commit_wid    (commit_wid),
    .csr_req_valid (csr_req_valid),
    .csr_req_ready (csr_req_ready),
    .csr_req_wid   (csr_req_wid),
    .csr_req_addr  (csr_req_addr),
    .csr_req_op    (csr_req_op),
    .csr_req_data  (csr_req_data),
    .csr_rsp_valid (csr_rsp_valid),
    .csr_rsp_ready (csr_rsp_ready),
    .csr_rsp_data  (csr_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int w = 0; w < NW; w++) begin
      m_ffl[w]  = 0;
      m_frm[w]  = 0;
      m_pend[w] = 0;
    end
    m_rsp_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic setIdle();
    read_wid      = '0;
    write_enable  = 1'b0;
    write_wid     = '0;
    write_fflags  = '0;
    issue_valid   = 1'b0;
    issue_wid     = '0;
    commit_valid  = 1'b0;
    commit_wid    = '0;
    csr_req_valid = 1'b0;
    csr_req_wid   = '0;
    csr_req_addr  = '0;
    csr_req_op    = '0;
    csr_req_data  = '0;
    csr_rsp_ready = 1'b1;
  endtask

  task automatic csrReq(input int wid, input int addr, input int op, input int unsigned data);
    csr_req_valid = 1'b1;
    csr_req_wid   = 3'(wid);
    csr_req_addr  = 12'(addr);
    csr_req_op    = 2'(op);
    csr_req_data  = data;
  endtask

  // Called just after a rising edge with inputs already driven; checks, advances the model, and
  // returns just after the next rising edge.
  task automatic applyStimulus();
    bit          exp_iready, exp_rready, busy, acc;
    int          w;
    int unsigned d, old_v, new_v;
    #1;
    exp_iready = (m_pend[issue_wid] < PMAX);
    busy       = ((csr_req_addr == 12'h001) || (csr_req_addr == 12'h003)) && (m_pend[csr_req_wid] != 0);
    exp_rready = !(m_rsp_valid && !csr_rsp_ready) && !busy;
    checkOutput("rsp_valid", 32'(csr_rsp_valid), 32'(m_rsp_valid));
    checkOutput("issue_ready", 32'(issue_ready), 32'(exp_iready));
    checkOutput("req_ready", 32'(csr_req_ready), 32'(exp_rready));
    checkOutput("read_frm", 32'(read_frm), 32'(m_frm[read_wid]));

    acc = csr_req_valid && exp_rready;
    if (acc) begin
      w = int'(csr_req_wid);
      d = csr_req_data;
      case (csr_req_addr)
        12'h001: old_v = m_ffl[w];
        12'h002: old_v = m_frm[w];
        12'h003: old_v = m_frm[w] * 32 + m_ffl[w];
        default: old_v = 0;
      endcase
      exp_q.push_back(old_v);
      case (csr_req_op)
        2'd0:    new_v = d;
        2'd1:    new_v = old_v | d;
        2'd2:    new_v = old_v & ~d;
        default: new_v = old_v;
      endcase
      case (csr_req_addr)
        12'h001: m_ffl[w] = new_v % 32;
        12'h002: m_frm[w] = new_v % 8;
        12'h003: begin
          m_ffl[w] = new_v % 32;
          m_frm[w] = (new_v / 32) % 8;
        end
        default: ;
      endcase
    end
    if (issue_valid && exp_iready) m_pend[issue_wid]++;
    if (commit_valid && m_pend[commit_wid] > 0) m_pend[commit_wid]--;
    if (write_enable) m_ffl[write_wid] = m_ffl[write_wid] | int'(write_fflags);
    if (acc) m_rsp_valid = 1'b1;
    else if (csr_rsp_ready) m_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: compares whatever the DUT presents against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (csr_rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("rsp_data", csr_rsp_data, exp_q[0]);
          if (csr_rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit found;
    int start, cw;
    setIdle();
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(csr_rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", csr_rsp_data, 32'd0);
    checkOutput("reset_issue_ready", 32'(issue_ready), 32'd1);
    reset = 1'b0;

    // Read fcsr right after reset, then sweep read_frm across warps.
    csrReq(0, 12'h003, 1, 0);
    applyStimulus();
    setIdle();
    for (int w = 0; w < NW; w++) begin
      read_wid = 3'(w);
      applyStimulus();
    end

    // Sticky fflags accrual on warp 2.
    write_enable = 1'b1; write_wid = 3'd2; write_fflags = 5'h01;
    applyStimulus();
    write_fflags = 5'h04;
    applyStimulus();
    setIdle();
    csrReq(2, 12'h001, 1, 0);
    applyStimulus();
    setIdle();

    // fflags access to warp 1 waits for its in-flight op to retire.
    issue_valid = 1'b1; issue_wid = 3'd1;
    applyStimulus();
    setIdle();
    csrReq(1, 12'h001, 1, 0);
    applyStimulus();
    applyStimulus();
    commit_valid = 1'b1; commit_wid = 3'd1;
    write_enable = 1'b1; write_wid = 3'd1; write_fflags = 5'h02;
    applyStimulus();
    commit_valid = 1'b0; write_enable = 1'b0;
    applyStimulus();
    setIdle();
    applyStimulus();

    // frm write visible next cycle; fcsr set of bit 7 on a warp with accrued flags.
    csrReq(3, 12'h002, 0, 3);
    applyStimulus();
    setIdle();
    read_wid = 3'd3;
    applyStimulus();
    write_enable = 1'b1; write_wid = 3'd4; write_fflags = 5'h09;
    applyStimulus();
    setIdle();
    csrReq(4, 12'h003, 1, 32'h80);
    applyStimulus();
    setIdle();
    read_wid = 3'd4;
    csrReq(4, 12'h003, 1, 0);
    applyStimulus();
    setIdle();
    csrReq(5, 12'h7ff, 0, 32'hff);
    applyStimulus();
    setIdle();
    applyStimulus();

    // Fill warp 0 to the in-flight limit, then issue+commit at and below the limit.
    for (int i = 0; i < PMAX + 1; i++) begin
      issue_valid = 1'b1; issue_wid = 3'd0;
      applyStimulus();
    end
    commit_valid = 1'b1; commit_wid = 3'd0;
    applyStimulus();
    applyStimulus();
    commit_valid = 1'b0;
    applyStimulus();
    setIdle();
    for (int i = 0; i < PMAX; i++) begin
      commit_valid = 1'b1; commit_wid = 3'd0;
      applyStimulus();
    end
    setIdle();
    applyStimulus();

    // Response backpressure, then reset while a response is held.
    csrReq(5, 12'h002, 1, 0);
    applyStimulus();
    csrReq(6, 12'h002, 1, 0);
    csr_rsp_ready = 1'b0;
    repeat (3) applyStimulus();
    reset = 1'b1;
    #1;
    checkOutput("midreset_rsp_valid", 32'(csr_rsp_valid), 32'd0);
    checkOutput("midreset_rsp_data", csr_rsp_data, 32'd0);
    resetModel();
    setIdle();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      setIdle();
      read_wid    = 3'($urandom_range(0, NW - 1));
      issue_valid = ($urandom_range(0, 99) < 35);
      issue_wid   = 3'($urandom_range(0, NW - 1));
      if ($urandom_range(0, 99) < 45) begin
        found = 1'b0;
        start = $urandom_range(0, NW - 1);
        for (int k = 0; k < NW; k++) begin
          cw = (start + k) % NW;
          if (!found && m_pend[cw] > 0) begin
            found = 1'b1;
            commit_valid = 1'b1;
            commit_wid = 3'(cw);
          end
        end
        if (found && $urandom_range(0, 1) == 1) begin
          write_enable = 1'b1;
          write_wid    = commit_wid;
          write_fflags = 5'($urandom_range(0, 31));
        end
      end
      if ($urandom_range(0, 99) < 45)
        csrReq($urandom_range(0, NW - 1), $urandom_range(1, 3), $urandom_range(0, 2), $urandom);
      csr_rsp_ready = ($urandom_range(0, 99) < 70);
      applyStimulus();
    end

    setIdle();
    repeat (4) applyStimulus();
    checkOutput("rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
